// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, imem req/ack fetch FSM and IF/ID register with stall/redirect handling.
// Optional misaligned-fetch flag fetch_adel is enabled by defining FETCH_ALIGN_CHECK_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_src,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_adel
`endif
);
  localparam logic [1:0] BOOT = 2'd0, REQ = 2'd1, DROP = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic [31:0] hold_instr, drop_addr, pc_load;
  logic adel, ack, redir, accept, clr, pc_we;
`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_load = pc_src;
  assign adel = fetch_adel;
  always_ff @(posedge clk)
    if (!rst_n) fetch_adel <= 1'b0;
    else if (pc_we) fetch_adel <= |pc_src[1:0];
`else
  assign pc_load = pc_src & 32'hFFFF_FFFC;
  assign adel = 1'b0;
`endif
  assign imem_req = state == DROP || (state == REQ && !adel);
  assign imem_addr = state == DROP ? drop_addr : pc;
  assign ack = imem_ack && imem_req;
  assign redir = redirect && state != BOOT;
  assign accept = !redirect && !stall && ((state == REQ && ack) || state == HOLD);
  assign clr = redir || (state == REQ && !ack && !stall);
  assign pc_we = redir || accept;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_pc    <= 32'h0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
      drop_addr  <= 32'h0;
    end else begin
      if (pc_we) pc <= pc_load;
      if (accept) begin
        ifid_pc    <= pc;
        ifid_instr <= state == HOLD ? hold_instr : imem_rdata;
        ifid_valid <= 1'b1;
      end else if (clr) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end
      case (state)
        BOOT: state <= REQ;
        REQ:
          if (redirect) begin
            // the outstanding address must stay on the bus until memory answers
            if (imem_req && !ack) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (ack && stall) begin
            hold_instr <= imem_rdata;
            state      <= HOLD;
          end
        HOLD: if (redirect || !stall) state <= REQ;
        default: if (ack) state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed plus randomized bench against a transaction-level fetch model.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_3000, NOP = 32'h0000_0000;
  logic clk = 0, rst_n = 0, redirect = 0, stall = 0, imem_ack = 0;
  logic imem_req, ifid_valid;
  logic [31:0] pc_src = 0, imem_rdata = 0, imem_addr, pc, ifid_pc, ifid_instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_adel;
`endif
  int checks = 0, errors = 0;
  bit m_boot, m_stale, m_adel, m_if_v;
  logic [31:0] m_pc, m_stale_addr, m_if_pc, m_if_instr;
  logic [31:0] m_held[$];

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .redirect(redirect), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_adel(fetch_adel)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // memory is asked for the stale address until it answers, otherwise for pc unless blocked
  function automatic bit exp_req();
    return !m_boot && (m_stale || (m_held.size() == 0 && !m_adel));
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic load(input logic [31:0] src);
`ifdef FETCH_ALIGN_CHECK_EN
    m_pc = src;
    m_adel = src[1:0] != 2'b00;
`else
    m_pc = {src[31:2], 2'b00};
`endif
  endtask

  task automatic flush();
    m_if_v = 0;
    m_if_instr = NOP;
  endtask

  task automatic deliver(input logic [31:0] ins);
    m_if_pc = m_pc;
    m_if_instr = ins;
    m_if_v = 1;
    load(pc_src);
  endtask

  task automatic model_step();
    bit req, acked;
    logic [31:0] old_pc;
    req = exp_req();
    acked = imem_ack && req;
    old_pc = m_pc;
    if (!rst_n) begin
      m_boot = 1; m_stale = 0; m_adel = 0; m_held.delete();
      m_pc = RST_PC; m_if_pc = 0; m_if_instr = NOP; m_if_v = 0;
    end else if (m_boot) m_boot = 0;
    else if (m_stale) begin
      if (redirect) begin flush(); load(pc_src); end
      if (acked) m_stale = 0;
    end else if (m_held.size() != 0) begin
      if (redirect) begin m_held.delete(); flush(); load(pc_src); end
      else if (!stall) deliver(m_held.pop_front());
    end else if (redirect) begin
      flush();
      load(pc_src);
      if (req && !acked) begin m_stale = 1; m_stale_addr = old_pc; end
    end else if (acked) begin
      if (stall) m_held.push_back(imem_rdata);
      else deliver(imem_rdata);
    end else if (!stall) flush();
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_if_v});
    check("ifid_pc", ifid_pc, m_if_pc);
    check("ifid_instr", ifid_instr, m_if_instr);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
    if (exp_req()) check("imem_addr", imem_addr, exp_addr());
`ifdef FETCH_ALIGN_CHECK_EN
    check("fetch_adel", {31'b0, fetch_adel}, {31'b0, m_adel});
`endif
  endtask

  task automatic tick(input bit r, input bit s, input bit rd, input bit a, input logic [31:0] tgt);
    rst_n = r; stall = s; redirect = rd; imem_ack = a;
    pc_src = rd ? tgt : m_pc + 32'd4;
    imem_rdata = exp_req() ? instr_of(exp_addr()) : $urandom;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit r, s, rd, a;
    logic [31:0] t;
    @(negedge clk);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    check("rst_pc", pc, RST_PC);
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_valid", {31'b0, ifid_valid}, 0);
    check("rst_ifid_pc", ifid_pc, 0);
    check("rst_instr", ifid_instr, NOP);
    tick(1, 0, 0, 1, 0);
    check("boot_addr", imem_addr, 32'h3000);
    tick(1, 0, 0, 1, 0);
    check("zw_pc1", pc, 32'h3004);
    check("zw_ifid1", ifid_pc, 32'h3000);
    check("zw_v1", {31'b0, ifid_valid}, 1);
    check("zw_ins1", ifid_instr, instr_of(32'h3000));
    tick(1, 0, 0, 1, 0);
    check("zw_pc2", pc, 32'h3008);
    check("zw_ifid2", ifid_pc, 32'h3004);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 1, 0);
      check("hold_pc", pc, 32'h3008);
      check("hold_req", {31'b0, imem_req}, 0);
    end
    tick(1, 0, 0, 1, 0);
    check("rel_ifid", ifid_pc, 32'h3008);
    check("rel_ins", ifid_instr, instr_of(32'h3008));
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 32'h4000);
    check("drop_addr", imem_addr, 32'h300C);
    check("drop_pc", pc, 32'h4000);
    tick(1, 0, 0, 0, 0);
    check("drop_addr2", imem_addr, 32'h300C);
    tick(1, 0, 0, 1, 0);
    check("drop_next", imem_addr, 32'h4000);
    check("drop_v", {31'b0, ifid_valid}, 0);
    tick(1, 0, 0, 1, 0);
    check("tgt_ifid", ifid_pc, 32'h4000);
    tick(1, 1, 0, 1, 0);
    tick(1, 1, 1, 0, 32'h5000);
    check("hr_pc", pc, 32'h5000);
    check("hr_v", {31'b0, ifid_valid}, 0);
    check("hr_req", {31'b0, imem_req}, 1);
    tick(0, 0, 0, 0, 0);
    check("mid_rst_req", {31'b0, imem_req}, 0);
    check("mid_rst_pc", pc, RST_PC);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 1, 32'h4002);
`ifdef FETCH_ALIGN_CHECK_EN
    check("adel_set", {31'b0, fetch_adel}, 1);
    check("adel_req", {31'b0, imem_req}, 0);
`else
    check("mask_addr", imem_addr, 32'h4000);
`endif
    tick(1, 0, 1, 1, 32'h5000);
    check("adel_clr_addr", imem_addr, 32'h5000);
    check("adel_clr_req", {31'b0, imem_req}, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99) != 0;
      s = $urandom_range(3) == 0;
      rd = $urandom_range(7) == 0;
      a = ((i / 500) % 2 == 1) ? 1'b1 : ($urandom_range(2) == 0);
      t = ($urandom & 32'h0000_FFFC) | (($urandom_range(9) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      tick(r, s, rd, a, t);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
